// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
// State encoding, BCD digit type and decimal radix constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RUN,
    DONE
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX   = 4'd9;
  localparam logic [4:0] BCD_RADIX = 5'd10;

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder step (combinational).
// Ports: a, b digits, cin in; s digit, cout decimal carry out.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t s,
  output logic       cout
);

  logic [4:0] t;

  always_comb begin
    t    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    cout = t > {1'b0, BCD_MAX};
    s    = cout ? bcd_digit_t'(t - BCD_RADIX) : t[3:0];
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD add/subtract, one digit per clock.
// Ports: start/sub/cin/a/b in; busy/done/sum/cout/err out.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  input  logic                   start,
  input  logic                   sub,
  input  logic                   cin,
  input  logic [4*NDIGITS-1:0]   a,
  input  logic [4*NDIGITS-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   sum,
  output logic                   cout,
  output logic                   err
);

  localparam int W  = 4 * NDIGITS;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  state_t         state;
  state_t         nstate;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   acc;
  logic [W-1:0]   acc_nx;
  logic           sub_q;
  logic           cin_q;
  logic           c_q;
  logic [IW-1:0]  idx;
  logic           last;
  logic           bad;
  bcd_digit_t     ad;
  bcd_digit_t     bd;
  bcd_digit_t     bx;
  bcd_digit_t     sd;
  logic           cd;

  bcd_digit_add u_dig (
    .a    (ad),
    .b    (bx),
    .cin  (c_q),
    .s    (sd),
    .cout (cd)
  );

  always_comb begin
    ad     = a_q[4*idx +: 4];
    bd     = b_q[4*idx +: 4];
    // nine's complement of b turns a - b into a + b' + 1
    bx     = sub_q ? (BCD_MAX - bd) : bd;
    acc_nx = acc;
    acc_nx[4*idx +: 4] = sd;
    last   = (idx == IW'(NDIGITS - 1));
  end

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (a_q[4*i +: 4] > BCD_MAX ||
          b_q[4*i +: 4] > BCD_MAX)
        bad = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (start) nstate = CHECK;
      CHECK: nstate = bad ? DONE : RUN;
      RUN:   if (last) nstate = DONE;
      DONE:  nstate = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      cin_q <= 1'b0;
      c_q   <= 1'b0;
      idx   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            cin_q <= cin;
          end
        end
        CHECK: begin
          idx <= '0;
          acc <= '0;
          c_q <= sub_q | cin_q;
          if (bad) begin
            sum  <= '0;
            cout <= 1'b0;
            err  <= 1'b1;
          end
        end
        RUN: begin
          acc <= acc_nx;
          c_q <= cd;
          idx <= idx + 1'b1;
          if (last) begin
            idx  <= '0;
            sum  <= acc_nx;
            cout <= cd;
            err  <= 1'b0;
          end
        end
        DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (NDIGITS=4).
// Directed cases plus random ops against a decimal model.
module tb_bcd_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int pass_n = 0;
  int total_n = 0;

  bcd_serial_adder #(.NDIGITS(N)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .start    (start),
    .sub      (sub),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // decimal reference: decode, add/subtract as integers, re-encode
  function automatic void model(input logic [W-1:0] ma,
                                input logic [W-1:0] mb,
                                input logic ms,
                                input logic mc,
                                output logic [W-1:0] es,
                                output logic ec,
                                output logic ee);
    int av = 0;
    int bv = 0;
    int p = 1;
    int r;
    int da;
    int db;
    ee = 1'b0;
    for (int i = 0; i < N; i++) begin
      da = int'(ma[4*i +: 4]);
      db = int'(mb[4*i +: 4]);
      if (da > 9 || db > 9) ee = 1'b1;
      av += da * p;
      bv += db * p;
      p *= 10;
    end
    es = '0;
    ec = 1'b0;
    if (!ee) begin
      r = ms ? (av - bv + p) : (av + bv + int'(mc));
      ec = (r >= p);
      r = r % p;
      for (int i = 0; i < N; i++) begin
        es[4*i +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end
  endfunction

  task automatic run_op(input logic [W-1:0] ta,
                        input logic [W-1:0] tb2,
                        input logic ts,
                        input logic tc,
                        input string tag);
    logic [W-1:0] es;
    logic ec;
    logic ee;
    int n;
    int lat;
    model(ta, tb2, ts, tc, es, ec, ee);
    lat = ee ? 2 : N + 2;
    @(negedge clk);
    a = ta; b = tb2; sub = ts; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".busy"}, busy, 1);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = ~ts;
    cin = ~tc;
    n = 1;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, cout, ec);
    chk({tag, ".err"}, err, ee);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, {busy, done}, 0);
    chk({tag, ".hold"}, sum, es);
  endtask

  initial begin
    int dn;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.out", {busy, done, cout, err}, 0);
    chk("rst.sum", sum, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h8766, 1'b0, 1'b0, "add");
    run_op(16'h9999, 16'h0000, 1'b0, 1'b1, "chain");
    run_op(16'h5000, 16'h1234, 1'b1, 1'b0, "subp");
    run_op(16'h1234, 16'h5000, 1'b1, 1'b0, "subn");
    run_op(16'h5000, 16'h1234, 1'b1, 1'b1, "subcin");
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, "subz");
    run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, "inv");
    run_op(16'h0001, 16'hF000, 1'b1, 1'b0, "invb");

    // start held high: one op per IDLE visit
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0;
    start = 1'b1;
    dn = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) begin
        dn++;
        chk("hold.sum", sum, 16'h0002);
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) begin
        dn++;
        chk("hold.sum", sum, 16'h0002);
      end
    end
    chk("hold.count", dn, 2);

    // reset in the middle of RUN
    run_op(16'h0042, 16'h0001, 1'b0, 1'b0, "pre");
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid.busy", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid.rst", {busy, done, cout, err}, 0);
    chk("mid.sum", sum, 0);
    dn = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("mid.nodone", dn, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0005, 16'h0005, 1'b0, 1'b0, "post");

    for (int k = 0; k < 25; k++) begin
      ra = '0;
      rb = '0;
      for (int i = 0; i < N; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 5) == 0)
        ra[4*$urandom_range(0, N-1) +: 4] = 4'($urandom_range(10, 15));
      run_op(ra, rb, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), "rnd");
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 SHALL have parameter NDIGITS, default 4, meaning the number of BCD digits per operand (legal range 1..16).
REQ-002 SHALL have port CLOCK_50  in  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  request to begin an operation.
REQ-005 SHALL have port sub  in  1  0 = add, 1 = subtract (a - b).
REQ-006 SHALL have port cin  in  1  carry-in, used in add mode only.
REQ-007 SHALL have port a  in  4*NDIGITS  BCD operand A; digit 0 is in bits [3:0].
REQ-008 SHALL have port b  in  4*NDIGITS  BCD operand B, same layout as a.
REQ-009 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  out  1  one-cycle pulse marking the result update.
REQ-011 SHALL have port sum  out  4*NDIGITS  BCD result.
REQ-012 SHALL have port cout  out  1  final decimal carry (in subtract mode, 1 = no borrow).
REQ-013 SHALL have port err  out  1  high when the last operation had an operand digit greater than 9.

Function
REQ-014 SHALL implement states IDLE, CHECK, RUN and DONE.
REQ-015 IDLE with start=1 SHALL register a, b, sub and cin, then move to CHECK; start in any other state SHALL be ignored.
REQ-016 CHECK SHALL go to DONE with pending err=1 if any registered digit of a or b exceeds 9; otherwise it SHALL go to RUN with digit index 0.
REQ-017 RUN SHALL process one digit per cycle, from index 0 to NDIGITS-1, then move to DONE.
REQ-018 Digit step: t = a_d + b'_d + c, using a 5-bit value (maximum 19); if t > 9 then s = t - 10 and c = 1, else s = t and c = 0.
REQ-019 Add mode SHALL use b'_d = b_d and an initial c = cin.
REQ-020 Subtract mode SHALL use b'_d = 9 - b_d and an initial c = 1, ignoring cin.
REQ-021 On A < B in subtract mode, sum SHALL be the 10's complement and cout SHALL be 0.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 sum, cout and err SHALL update only on the edge that enters DONE, and SHALL hold until the next DONE.
REQ-024 On err, sum SHALL be all zero and cout SHALL be 0.
REQ-025 Latency from the start-sampling edge to done high SHALL be NDIGITS+2 cycles for valid operands and 2 cycles for invalid operands.
REQ-026 A start sampled on the same edge that leaves DONE SHALL be ignored; the next start is accepted in IDLE.

Reset
REQ-027 RESET_N low SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, err=0, digit index 0, and clear all operand registers.
REQ-028 Reset mid-operation SHALL abandon the operation with no done pulse; the first start after RESET_N rises SHALL be processed normally.

Structure
REQ-029 Package bcd_pkg SHALL hold the state enum, a 4-bit bcd_digit_t typedef, and the constants BCD_MAX=9 and BCD_RADIX=10.
REQ-030 A combinational sub-module bcd_digit_add SHALL implement the single-digit step of REQ-018, instantiated once and time-multiplexed.

Verification (NDIGITS=4)
REQ-031 Add: a=1234, b=8766, cin=0 -> sum=0000, cout=1, err=0, done 6 cycles after start.
REQ-032 Add with carry chain: a=9999, b=0000, cin=1 -> sum=0000, cout=1.
REQ-033 Subtract: sub=1, a=5000, b=1234 -> sum=3766, cout=1; then a=1234, b=5000 -> sum=6234, cout=0.
REQ-034 Invalid digit: a=0x12A4, b=0001 -> err=1, sum=0000, cout=0, done 2 cycles after start, busy low the cycle after.
REQ-035 start held high for 10 cycles with a=0001, b=0001 -> exactly one operation per IDLE visit, each with sum=0002, and start ignored while busy.
REQ-036 RESET_N pulsed low during RUN (digit index 2) -> all outputs 0 at once, no done pulse, and a following start of 0005+0005 gives sum=0010.
